// File: rtl/hack_pkg.sv
// Shared types for the Hack branch unit.
//   jmp_e   : encoding of the C-instruction jump field {j1,j2,j3}
//   state_e : branch unit run state (RUN / HALT)
package hack_pkg;

    typedef enum logic [2:0] {
        JNULL = 3'b000,
        JGT   = 3'b001,
        JEQ   = 3'b010,
        JGE   = 3'b011,
        JLT   = 3'b100,
        JNE   = 3'b101,
        JLE   = 3'b110,
        JMP   = 3'b111
    } jmp_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational jump-condition decode for a Hack C-instruction.
// Ports:
//   jmp  - jump field {j1,j2,j3}
//   ng   - ALU output negative flag
//   zr   - ALU output zero flag
//   cond - high when the jump field's condition holds for the flags
module hack_jump_cond
    import hack_pkg::*;
(
    input  logic [2:0] jmp,
    input  logic       ng,
    input  logic       zr,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (jmp)
            JNULL:   cond = 1'b0;
            JGT:     cond = ~ng & ~zr;
            JEQ:     cond = zr;
            JGE:     cond = ~ng;
            JLT:     cond = ng;
            JNE:     cond = ~zr;
            JLE:     cond = ng | zr;
            JMP:     cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/hack_branch_unit.sv
// Hack CPU program-counter / branch unit.
// Ports:
//   clk, rst  - clock (rising edge) and async active-high reset
//   en        - advance; when low all state holds and taken drops
//   is_c      - current instruction is a C-instruction
//   jmp       - jump field {j1,j2,j3}
//   ng, zr    - ALU negative / zero flags
//   tgt       - jump target (A register)
//   pc        - registered program counter
//   taken     - one-cycle pulse in the cycle after a taken jump
//   taken_cnt - saturating count of taken jumps
//   halted    - unit is in HALT (entered on an unconditional jump to self)
//
// state | meaning
// RUN   | normal fetch: pc advances or jumps whenever en is high
// HALT  | parked after "JMP to self"; only rst leaves
module hack_branch_unit
    import hack_pkg::*;
#(
    parameter int              PC_W     = 15,
    parameter int              CNT_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             is_c,
    input  logic [2:0]       jmp,
    input  logic             ng,
    input  logic             zr,
    input  logic [PC_W-1:0]  tgt,
    output logic [PC_W-1:0]  pc,
    output logic             taken,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             halted
);

    logic             cond;
    logic             take;
    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    hack_jump_cond u_jump_cond (
        .jmp  (jmp),
        .ng   (ng),
        .zr   (zr),
        .cond (cond)
    );

    assign take = en & is_c & cond & (state_q == RUN);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        cnt_d   = cnt_q;
        if ((state_q == RUN) && en) begin
            pc_d    = take ? tgt : pc_q + PC_W'(1);
            taken_d = take;
            if (take && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Only the unconditional form of a self-jump parks the unit;
            // a conditional self-jump is a legitimate spin-wait.
            if (take && (jmp == JMP) && (tgt == pc_q)) begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign taken     = taken_q;
    assign taken_cnt = cnt_q;
    assign halted    = (state_q == HALT);

endmodule
